// File: rtl/cymo_pkg.sv
// Shared definitions for the equal-precision frequency meter: measurement FSM
// encoding and the constants common to gate_gen and the downstream divider.
package cymo_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_OPEN = 2'd1,
    MEAS      = 2'd2,
    DONE      = 2'd3
  } meas_state_t;

  localparam int CNT_W_DEF = 32;
  localparam int F_CLK     = 50_000_000;

endpackage

// File: rtl/sig_sync_edge.sv
// Multi-stage synchroniser for an asynchronous input followed by a registered
// rising-edge pulse; the pulse appears STAGES+1 clocks after the pin edge.
module sig_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [STAGES-1:0] sync;
  logic              last;

  // synchroniser chain, edge history and registered rising-edge pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {STAGES{1'b0}};
      last <= 1'b0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      last <= sync[STAGES-1];
      rise <= sync[STAGES-1] & ~last;
    end
  end

endmodule

// File: rtl/equ_prec_counter.sv
// Equal-precision counter: opens/closes the actual gate on synchronised sig_in
// rising edges and counts Clk cycles (fs) and signal periods (fx) inside it.
module equ_prec_counter #(
  parameter int CNT_W       = cymo_pkg::CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 100_000_000
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             gate_test,
  input  logic             sig_in,
  output logic [CNT_W-1:0] fx_cnt,
  output logic [CNT_W-1:0] fs_cnt,
  output logic             data_valid,
  output logic             timeout,
  output logic             no_sig
);
  import cymo_pkg::*;

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("equ_prec_counter: SYNC_STAGES must be at least 2");
    end
    if ((TIMEOUT < 2) || ((CNT_W < 63) && (longint'(TIMEOUT) >= (64'sd1 << CNT_W)))) begin : g_bad_timeout
      $error("equ_prec_counter: TIMEOUT must be at least 2 and below 2**CNT_W");
    end
  endgenerate

  localparam logic [CNT_W-1:0] ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  meas_state_t      state;
  logic             sig_rise;
  logic             gate_d;
  logic             armed;
  logic             gate_up;
  logic [CNT_W-1:0] fx;
  logic [CNT_W-1:0] fs;
  logic [CNT_W-1:0] fx_inc;
  logic [CNT_W-1:0] fs_inc;

  sig_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sig_sync (
    .clk  (Clk),
    .rst  (Rst),
    .din  (sig_in),
    .rise (sig_rise)
  );

  // armed stays low until the gate has been seen low once, so a gate that is
  // already high when reset releases cannot fake a rising edge
  assign gate_up = gate_test & ~gate_d & armed;
  assign fx_inc  = fx + (sig_rise ? ONE : ZERO);
  assign fs_inc  = fs + ONE;

  // measurement FSM; results are loaded on the closing edge so data_valid
  // coincides with the single DONE cycle
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      gate_d     <= 1'b0;
      armed      <= 1'b0;
      fx         <= ZERO;
      fs         <= ZERO;
      fx_cnt     <= ZERO;
      fs_cnt     <= ZERO;
      data_valid <= 1'b0;
      timeout    <= 1'b0;
      no_sig     <= 1'b0;
    end else begin
      gate_d     <= gate_test;
      armed      <= armed | ~gate_test;
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (gate_up) begin
            state <= WAIT_OPEN;
          end else begin
            state <= IDLE;
          end
        end
        WAIT_OPEN: begin
          if (sig_rise) begin
            state <= MEAS;
            fx    <= ZERO;
            fs    <= ZERO;
          end else if (!gate_test) begin
            state      <= DONE;
            fx_cnt     <= ZERO;
            fs_cnt     <= ZERO;
            data_valid <= 1'b1;
            timeout    <= 1'b0;
            no_sig     <= 1'b1;
          end else begin
            state <= WAIT_OPEN;
          end
        end
        MEAS: begin
          fx <= fx_inc;
          fs <= fs_inc;
          if (fs_inc == TO_LAST) begin
            state      <= DONE;
            fx_cnt     <= fx_inc;
            fs_cnt     <= fs_inc;
            data_valid <= 1'b1;
            timeout    <= 1'b1;
            no_sig     <= 1'b0;
          end else if (sig_rise && !gate_test) begin
            state      <= DONE;
            fx_cnt     <= fx_inc;
            fs_cnt     <= fs_inc;
            data_valid <= 1'b1;
            timeout    <= 1'b0;
            no_sig     <= 1'b0;
          end else begin
            state <= MEAS;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
